usb_token_rx_ctrl: RTL

USB_TOKEN_RX_CTRL -- requirements
Module: usb_token_rx_ctrl

---
 rtl/usb_pkg.sv | 26 ++
 rtl/usb_token_rx_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions: token PID codes and the token receiver state type.
`timescale 1ns/1ps
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_SOF   = 4'b0101;

  typedef enum logic [2:0] {
    StIdle,
    StPid,
    StField,
    StWaitEop,
    StErr
  } token_rx_state_e;

  // True when the byte carries a valid check nibble and one of the four token PIDs.
  function automatic logic pid_is_token(input logic [7:0] pid_byte);
    logic [3:0] code;
    code = pid_byte[3:0];
    return (code == ~pid_byte[7:4]) &&
           ((code == PID_OUT) || (code == PID_IN) || (code == PID_SETUP) || (code == PID_SOF));
  endfunction

endpackage

// File: rtl/usb_token_rx_ctrl.sv
// USB token packet receiver: validates the PID, steers the 16 field bits through an external
// CRC5 checker and reports a good or rejected token one cycle after the end of the packet.
`timescale 1ns/1ps
module usb_token_rx_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned EOP_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sop,
  input  logic       rx_bit,
  input  logic       bit_valid,
  input  logic       eop,
  input  logic       rx_err,
  input  logic       crc_pass,
  output logic       crc_clear,
  output logic       crc_shift_en,
  output logic       crc_serial,
  output logic [3:0] pid,
  output logic [6:0] addr,
  output logic [3:0] endp,
  output logic       token_valid,
  output logic       token_err,
  output logic       busy
);

  localparam int unsigned TmoW = $clog2(EOP_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(EOP_TIMEOUT - 1);

  token_rx_state_e state_q;
  logic [3:0]      bit_cnt_q;
  logic [7:0]      byte_q;
  logic [10:0]     field_q;
  logic [TmoW-1:0] tmo_q;
  logic [3:0]      pid_q;
  logic [6:0]      addr_q;
  logic [3:0]      endp_q;
  logic            token_valid_q;
  logic            token_err_q;

  logic [7:0] byte_next;
  logic       restart;

  assign byte_next = {rx_bit, byte_q[7:1]};
  assign restart   = sop && !rx_err;

  // The checker must see clear and shift in the same cycle as the triggering input.
  always_comb begin
    crc_clear    = 1'b0;
    crc_shift_en = 1'b0;
    if (state_q == StIdle) begin
      crc_clear = sop;
    end else begin
      crc_clear = restart;
    end
    crc_shift_en = (state_q == StField) && bit_valid && !rx_err && !sop && !eop;
  end

  assign crc_serial  = rx_bit;
  assign pid         = pid_q;
  assign addr        = addr_q;
  assign endp        = endp_q;
  assign token_valid = token_valid_q;
  assign token_err   = token_err_q;
  assign busy        = (state_q != StIdle);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      byte_q        <= '0;
      field_q       <= '0;
      tmo_q         <= '0;
      pid_q         <= 4'h0;
      addr_q        <= 7'h00;
      endp_q        <= 4'h0;
      token_valid_q <= 1'b0;
      token_err_q   <= 1'b0;
    end else begin
      token_valid_q <= 1'b0;
      token_err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sop) begin
            state_q   <= StPid;
            bit_cnt_q <= '0;
          end
        end
        StErr: begin
          // The error for this packet is already out; a fresh sop starts the next one.
          if (restart) begin
            state_q   <= StPid;
            bit_cnt_q <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          if (rx_err) begin
            state_q     <= StErr;
            token_err_q <= 1'b1;
          end else if (sop) begin
            state_q   <= StPid;
            bit_cnt_q <= '0;
          end else if (eop) begin
            if ((state_q == StWaitEop) && !bit_valid) begin
              state_q <= StIdle;
              if (crc_pass) begin
                token_valid_q <= 1'b1;
                pid_q         <= byte_q[3:0];
                addr_q        <= field_q[6:0];
                endp_q        <= field_q[10:7];
              end else begin
                token_err_q <= 1'b1;
              end
            end else begin
              state_q     <= StErr;
              token_err_q <= 1'b1;
            end
          end else if (state_q == StWaitEop) begin
            if (bit_valid || (tmo_q == TmoLast)) begin
              state_q     <= StErr;
              token_err_q <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TmoW'(1);
            end
          end else if (bit_valid) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (state_q == StPid) begin
              byte_q <= byte_next;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                if (pid_is_token(byte_next)) begin
                  state_q <= StField;
                end else begin
                  state_q     <= StErr;
                  token_err_q <= 1'b1;
                end
              end
            end else begin
              if (bit_cnt_q < 4'd11) begin
                field_q <= {rx_bit, field_q[10:1]};
              end
              if (bit_cnt_q == 4'd15) begin
                state_q <= StWaitEop;
                tmo_q   <= '0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
